// File: rtl/l1d_wb_cache.sv
// l1d_wb_cache: direct-mapped, write-back, write-allocate L1 data cache controller.
// Ports:
//   CLK, RST_N                    clock, synchronous active-low reset
//   REQ_VALID/READY/STORE/ADDR/WDATA  load/store request from the LSU
//   RESP_VALID, RESP_RDATA        registered one-cycle completion pulse, load data
//   FLUSH, FLUSH_DONE             write back dirty lines and invalidate all sets
//   MEM_REQ_VALID/READY/WRITE, MEM_ADDR, MEM_WDATA  word request to memory
//   MEM_RDATA_VALID, MEM_RDATA    read return; at most one read outstanding
module l1d_wb_cache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_STORE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RESP_VALID,
    output logic [DATA_W-1:0] RESP_RDATA,
    input  logic              FLUSH,
    output logic              FLUSH_DONE,
    output logic              MEM_REQ_VALID,
    input  logic              MEM_REQ_READY,
    output logic              MEM_REQ_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_RDATA_VALID,
    input  logic [DATA_W-1:0] MEM_RDATA
);
    localparam int BO_W  = $clog2(DATA_W / 8);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BO_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WB, S_FILL_REQ, S_FILL_WAIT, S_FLUSH_SCAN, S_FLUSH_WB
    } state_e;

    state_e             state_q, state_d;
    logic               store_q, store_d;
    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [OFF_W-1:0]   roff_q, roff_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   set_q, set_d;
    logic [SETS-1:0]    valid_q, valid_d, dirty_q, dirty_d;
    logic               resp_valid_q, resp_valid_d, flush_done_q, flush_done_d;
    logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;

    // Tag and data storage are not reset; valid bits make their contents meaningful.
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [DATA_W-1:0]  data_q [SETS][LINE_WORDS];
    logic               tag_we, data_we;
    logic [OFF_W-1:0]   data_woff;
    logic [DATA_W-1:0]  data_wdata;

    logic [TAG_W-1:0]   in_tag;
    logic [IDX_W-1:0]   in_idx, wb_idx;
    logic [OFF_W-1:0]   in_off;
    logic               in_hit, cmp_hit, mem_hs, last_w, last_s;
    logic               unused_addr;

    assign in_tag      = REQ_ADDR[ADDR_W-1 -: TAG_W];
    assign in_idx      = REQ_ADDR[BO_W+OFF_W +: IDX_W];
    assign in_off      = REQ_ADDR[BO_W +: OFF_W];
    assign unused_addr = ^REQ_ADDR;

    // The hit is looked up on the incoming address so RESP_VALID can be a flop
    // that is already high in the COMPARE cycle.
    assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign cmp_hit = valid_q[ridx_q] && (tag_q[ridx_q] == rtag_q);
    assign mem_hs  = MEM_REQ_VALID && MEM_REQ_READY;
    assign last_w  = (cnt_q == OFF_W'(LINE_WORDS - 1));
    assign last_s  = (set_q == IDX_W'(SETS - 1));
    assign wb_idx  = (state_q == S_FLUSH_WB) ? set_q : ridx_q;

    assign REQ_READY  = (state_q == S_IDLE) && !FLUSH && RST_N;
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;
    assign FLUSH_DONE = flush_done_q;

    always_comb begin
        MEM_REQ_VALID = 1'b0;
        MEM_REQ_WRITE = 1'b0;
        MEM_ADDR      = '0;
        MEM_WDATA     = '0;
        case (state_q)
            S_WB, S_FLUSH_WB: begin
                MEM_REQ_VALID = 1'b1;
                MEM_REQ_WRITE = 1'b1;
                MEM_ADDR      = ADDR_W'({tag_q[wb_idx], wb_idx, cnt_q}) << BO_W;
                MEM_WDATA     = data_q[wb_idx][cnt_q];
            end
            S_FILL_REQ: begin
                MEM_REQ_VALID = 1'b1;
                MEM_ADDR      = ADDR_W'({rtag_q, ridx_q, cnt_q}) << BO_W;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        rtag_d       = rtag_q;
        ridx_d       = ridx_q;
        roff_d       = roff_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        set_d        = set_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        flush_done_d = 1'b0;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        data_woff    = cnt_q;
        data_wdata   = MEM_RDATA;
        case (state_q)
            S_IDLE: begin
                if (FLUSH) begin
                    state_d = S_FLUSH_SCAN;
                    set_d   = '0;
                end else if (REQ_VALID && REQ_READY) begin
                    state_d = S_COMPARE;
                    store_d = REQ_STORE;
                    rtag_d  = in_tag;
                    ridx_d  = in_idx;
                    roff_d  = in_off;
                    wdata_d = REQ_WDATA;
                    if (in_hit) begin
                        resp_valid_d = 1'b1;
                        if (!REQ_STORE) resp_rdata_d = data_q[in_idx][in_off];
                    end
                end
            end
            S_COMPARE: begin
                cnt_d = '0;
                if (cmp_hit) begin
                    state_d = S_IDLE;
                    if (store_q) begin
                        data_we         = 1'b1;
                        data_woff       = roff_q;
                        data_wdata      = wdata_q;
                        dirty_d[ridx_q] = 1'b1;
                    end
                end else if (valid_q[ridx_q] && dirty_q[ridx_q]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FILL_REQ;
                end
            end
            S_WB: begin
                if (mem_hs) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (last_w) state_d = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                if (mem_hs) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (MEM_RDATA_VALID) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (last_w) begin
                        // Line is complete, so the replayed COMPARE is a hit.
                        state_d         = S_COMPARE;
                        tag_we          = 1'b1;
                        valid_d[ridx_q] = 1'b1;
                        dirty_d[ridx_q] = 1'b0;
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = (roff_q == cnt_q) ? MEM_RDATA : data_q[ridx_q][roff_q];
                    end else begin
                        state_d = S_FILL_REQ;
                    end
                end
            end
            S_FLUSH_SCAN: begin
                cnt_d = '0;
                if (valid_q[set_q] && dirty_q[set_q]) begin
                    state_d = S_FLUSH_WB;
                end else begin
                    valid_d[set_q] = 1'b0;
                    set_d          = set_q + IDX_W'(1);
                    if (last_s) begin
                        state_d      = S_IDLE;
                        flush_done_d = 1'b1;
                    end
                end
            end
            S_FLUSH_WB: begin
                if (mem_hs) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (last_w) begin
                        valid_d[set_q] = 1'b0;
                        dirty_d[set_q] = 1'b0;
                        set_d          = set_q + IDX_W'(1);
                        if (last_s) begin
                            state_d      = S_IDLE;
                            flush_done_d = 1'b1;
                        end else begin
                            state_d = S_FLUSH_SCAN;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            store_q      <= 1'b0;
            rtag_q       <= '0;
            ridx_q       <= '0;
            roff_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            set_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            rtag_q       <= rtag_d;
            ridx_q       <= ridx_d;
            roff_q       <= roff_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            set_q        <= set_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && tag_we)  tag_q[ridx_q] <= rtag_q;
        if (RST_N && data_we) data_q[ridx_q][data_woff] <= data_wdata;
    end

endmodule

// File: tb/tb_l1d_wb_cache.sv
// tb_l1d_wb_cache: directed + randomized bench for l1d_wb_cache against a
// line-level reference cache and a word-addressed memory image.
module tb_l1d_wb_cache;
    localparam int AW = 32, DW = 32, L = 4, S = 16;

    logic          CLK = 1'b0, RST_N = 1'b0;
    logic          REQ_VALID = 1'b0, REQ_STORE = 1'b0, FLUSH = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          REQ_READY, RESP_VALID, FLUSH_DONE;
    logic [DW-1:0] RESP_RDATA;
    logic          MEM_REQ_VALID, MEM_REQ_WRITE;
    logic          MEM_REQ_READY = 1'b1, MEM_RDATA_VALID = 1'b0;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA = '0;

    always #5 CLK = ~CLK;

    l1d_wb_cache #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(L), .SETS(S)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_STORE(REQ_STORE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA),
        .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE),
        .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_READY(MEM_REQ_READY),
        .MEM_REQ_WRITE(MEM_REQ_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA_VALID(MEM_RDATA_VALID), .MEM_RDATA(MEM_RDATA)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory images (bus side and reference side) ----------------
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : dflt(wa);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] obs_wa[$], obs_wd[$], obs_ra[$];
    bit          rand_stall = 0, pend = 0, holding = 0, forced;
    int          force_stall = 0, stall_cyc = 0;
    logic [31:0] pend_wa, h_addr, h_wdata;
    logic        h_write;

    initial begin
        forever begin
            @(negedge CLK);
            MEM_RDATA_VALID = pend;
            MEM_RDATA       = pend ? bus_rd(pend_wa) : 32'h0;
            pend            = 0;
            forced          = 0;
            if (force_stall > 0 && MEM_REQ_VALID && MEM_REQ_WRITE) begin
                MEM_REQ_READY = 1'b0;
                force_stall--;
                forced = 1;
            end else begin
                MEM_REQ_READY = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (holding && RST_N) begin
                chk("hold_valid", MEM_REQ_VALID, 1);
                chk("hold_write", MEM_REQ_WRITE, h_write);
                chk("hold_addr", MEM_ADDR, h_addr);
                chk("hold_wdata", MEM_WDATA, h_wdata);
            end
            holding = 0;
            if (MEM_REQ_VALID && RST_N) begin
                if (MEM_REQ_READY) begin
                    if (MEM_REQ_WRITE) begin
                        obs_wa.push_back(MEM_ADDR);
                        obs_wd.push_back(MEM_WDATA);
                        bus_mem[MEM_ADDR >> 2] = MEM_WDATA;
                    end else begin
                        obs_ra.push_back(MEM_ADDR);
                        pend    = 1;
                        pend_wa = MEM_ADDR >> 2;
                    end
                end else begin
                    holding = 1;
                    h_addr  = MEM_ADDR;
                    h_wdata = MEM_WDATA;
                    h_write = MEM_REQ_WRITE;
                    if (!forced) stall_cyc++;
                end
            end
        end
    end

    // ---------------- reference cache ----------------
    bit          m_valid [S];
    bit          m_dirty [S];
    int unsigned m_tag   [S];
    logic [31:0] m_data  [S][L];
    logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];

    task automatic mem_set(input logic [31:0] addr, input logic [31:0] d);
        bus_mem[addr >> 2] = d;
        ref_mem[addr >> 2] = d;
    endtask

    task automatic model_wb(input int s);
        for (int w = 0; w < L; w++) begin
            logic [31:0] wa;
            wa = (m_tag[s] * S + s) * L + w;
            exp_wa.push_back(wa << 2);
            exp_wd.push_back(m_data[s][w]);
            ref_mem[wa] = m_data[s][w];
        end
    endtask

    task automatic model_access(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic [31:0] rd);
        int unsigned wa, off, idx, tag;
        wa  = addr >> 2;
        off = wa % L;
        idx = (wa / L) % S;
        tag = wa / (L * S);
        lat = 1;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                model_wb(idx);
                lat += L;
            end
            for (int w = 0; w < L; w++) begin
                int unsigned la;
                la = (tag * S + idx) * L + w;
                exp_ra.push_back(la << 2);
                m_data[idx][w] = ref_rd(la);
            end
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tag;
            lat += 2 * L + 1;
        end
        if (st) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1;
        end
        rd = m_data[idx][off];
    endtask

    task automatic cmp_mem(input string tag);
        chk({tag, "_nwr"}, obs_wa.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
            chk({tag, "_wr_addr"}, obs_wa[i], exp_wa[i]);
            chk({tag, "_wr_data"}, obs_wd[i], exp_wd[i]);
        end
        chk({tag, "_nrd"}, obs_ra.size(), exp_ra.size());
        for (int i = 0; i < exp_ra.size() && i < obs_ra.size(); i++)
            chk({tag, "_rd_addr"}, obs_ra[i], exp_ra[i]);
        obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic do_req(input bit st, input logic [31:0] addr, input logic [31:0] wd, input int extra);
        int lat, el, s0, n;
        logic [31:0] er;
        model_access(st, addr, wd, el, er);
        s0        = stall_cyc;
        REQ_VALID = 1'b1;
        REQ_STORE = st;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        n = 0;
        while (!REQ_READY && n < 100) begin tick(); n++; end
        chk("req_ready", REQ_READY, 1);
        tick();
        REQ_VALID = 1'b0;
        REQ_STORE = 1'b0;
        lat = 1;
        while (!RESP_VALID && lat < 500) begin tick(); lat++; end
        chk("resp_lat", lat, el + extra + (stall_cyc - s0));
        if (!st) chk("resp_rdata", RESP_RDATA, er);
        tick();
        chk("resp_pulse", RESP_VALID, 0);
        cmp_mem("req");
    endtask

    task automatic do_flush(input bit with_req);
        int nd, lat, s0, nresp;
        nd = 0;
        nresp = 0;
        for (int s = 0; s < S; s++) begin
            if (m_valid[s] && m_dirty[s]) begin model_wb(s); nd++; end
            m_valid[s] = 0;
            m_dirty[s] = 0;
        end
        s0    = stall_cyc;
        FLUSH = 1'b1;
        if (with_req) begin
            REQ_VALID = 1'b1;
            REQ_STORE = 1'b0;
            REQ_ADDR  = 32'h100;
        end
        #1;
        chk("flush_req_ready", REQ_READY, 0);
        tick();
        FLUSH     = 1'b0;
        REQ_VALID = 1'b0;
        lat = 1;
        while (!FLUSH_DONE && lat < 3000) begin nresp += RESP_VALID; tick(); lat++; end
        chk("flush_lat", lat, S + 1 + L * nd + (stall_cyc - s0));
        chk("flush_done_ready", REQ_READY, 1);
        chk("flush_no_resp", nresp, 0);
        tick();
        chk("flush_pulse", FLUSH_DONE, 0);
        cmp_mem("flush");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nbad;
        for (int i = 0; i < L; i++) mem_set(32'h100 + 4 * i, 32'hA0 + i);

        // reset values
        RST_N = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", REQ_READY, 0);
        chk("rst_resp_valid", RESP_VALID, 0);
        chk("rst_resp_rdata", RESP_RDATA, 0);
        chk("rst_flush_done", FLUSH_DONE, 0);
        chk("rst_mem_valid", MEM_REQ_VALID, 0);
        chk("rst_mem_write", MEM_REQ_WRITE, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_mem_wdata", MEM_WDATA, 0);
        RST_N = 1'b1;
        tick();
        chk("rst_release_ready", REQ_READY, 1);

        // clean miss, then hit on the same line
        do_req(0, 32'h100, 0, 0);
        do_req(0, 32'h104, 0, 0);
        // store hit and readback with no memory traffic
        do_req(1, 32'h108, 32'hDEADBEEF, 0);
        do_req(0, 32'h108, 0, 0);
        // dirty miss: set 0 tag 1 evicted by 0x200
        do_req(0, 32'h200, 0, 0);
        // dirty miss with memory stalled 5 cycles during write-back
        do_req(1, 32'h200, 32'hCAFE0200, 0);
        force_stall = 5;
        do_req(0, 32'h100, 0, 5);
        chk("stall_consumed", force_stall, 0);

        // flush with sets 0 and 3 dirty, then 0x100 misses
        do_req(1, 32'h100, 32'h11110000, 0);
        do_req(0, 32'h030, 0, 0);
        do_req(1, 32'h034, 32'h33330000, 0);
        do_flush(0);
        do_req(0, 32'h100, 0, 0);
        // flush and request in the same cycle: flush wins
        do_flush(1);

        // reset during FILL_WAIT
        REQ_VALID = 1'b1;
        REQ_STORE = 1'b0;
        REQ_ADDR  = 32'h400;
        chk("rstmid_ready", REQ_READY, 1);
        tick();
        REQ_VALID = 1'b0;
        repeat (2) tick();
        RST_N = 1'b0;
        nbad  = 0;
        repeat (2) begin tick(); nbad += RESP_VALID + FLUSH_DONE; end
        chk("rstmid_no_pulse", nbad, 0);
        RST_N = 1'b1;
        tick();
        chk("rstmid_ready_after", REQ_READY, 1);
        for (int s = 0; s < S; s++) begin m_valid[s] = 0; m_dirty[s] = 0; end
        obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
        do_req(0, 32'h100, 0, 0);

        // randomized traffic over a small aliasing address space
        rand_stall = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_flush(bit'($urandom_range(0, 1)));
            end else begin
                logic [31:0] a;
                a = (($urandom_range(0, 3) * S * L + $urandom_range(0, S * L - 1)) << 2)
                    | $urandom_range(0, 3);
                do_req(bit'($urandom_range(0, 1)), a, $urandom, 0);
            end
        end
        rand_stall = 0;
        do_flush(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
